// File: rtl/data_mem_stage.sv
// MEM-stage data memory: byte/half/word stores into a synchronous-write RAM, combinational
// loads with sign/zero extension, and capture of the first illegal access for debug.
module data_mem_stage #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        AccessErr,
    output logic        ErrSticky,
    output logic [31:0] ErrAddr
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_q [Depth];
    logic                  err_sticky_q, err_sticky_d;
    logic [31:0]           err_addr_q, err_addr_d;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  illegal;
    logic                  wr_en;
    logic [3:0]            byte_en;
    logic [31:0]           wr_data;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [15:0]           rd_half;
    logic [31:0]           load_val;

    assign word_idx = ALUResult[ADDR_WIDTH+1:2];
    assign lane     = ALUResult[1:0];

    always_comb begin
        illegal = 1'b0;
        unique case (MemSize)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = lane[0];
            2'b10:   illegal = (lane != 2'b00);
            default: illegal = 1'b1;
        endcase
        if (MemRead && MemWrite) begin
            illegal = 1'b1;
        end
    end

    assign AccessErr = (MemRead | MemWrite) & illegal;
    assign wr_en     = MemWrite & ~AccessErr;

    // Replicate the store data across lanes so each lane enable picks its own slice.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = WriteData;
        unique case (MemSize)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{WriteData[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wr_data = WriteData;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = WriteData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (byte_en[l]) begin
                    mem_q[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
                end
            end
        end
    end

    assign rd_word  = mem_q[word_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};
    assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = '0;
        unique case (MemSize)
            2'b00:   load_val = {{24{~MemUnsigned & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{~MemUnsigned & rd_half[15]}}, rd_half};
            2'b10:   load_val = rd_word;
            default: load_val = '0;
        endcase
    end

    assign ReadData = (MemRead && !AccessErr && !reset) ? load_val : 32'h0;

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (AccessErr && !err_sticky_q) begin
            err_sticky_d = 1'b1;
            err_addr_d   = ALUResult;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign ErrSticky = err_sticky_q;
    assign ErrAddr   = err_addr_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: directed accesses push expectations, a negedge
// monitor pops and compares whenever a request is presented.
module tb_data_mem_stage;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        AccessErr;
    logic        ErrSticky;
    logic [31:0] ErrAddr;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
        logic        sticky;
        logic [31:0] eaddr;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    data_mem_stage #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemUnsigned(MemUnsigned),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .AccessErr  (AccessErr),
        .ErrSticky  (ErrSticky),
        .ErrAddr    (ErrAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input string name, input logic rst, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input logic exp_sticky, input logic [31:0] exp_eaddr);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        MemRead     = rd;
        MemWrite    = wr;
        MemSize     = sz;
        MemUnsigned = uns;
        ALUResult   = a;
        WriteData   = wd;
        e.name   = name;
        e.rd     = exp_rd;
        e.err    = exp_err;
        e.sticky = exp_sticky;
        e.eaddr  = exp_eaddr;
        sb.push_back(e);
    endtask

    // Idle cycles leave MemSize at the reserved code so a spurious AccessErr would show.
    task automatic idle(input logic rst);
        @(posedge clk);
        #1;
        reset    = rst;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemSize  = 2'b11;
        ALUResult = 32'h0000_0001;
        WriteData = 32'hFFFF_FFFF;
    endtask

    always @(negedge clk) begin
        if (MemRead || MemWrite) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_request: got request with empty scoreboard, expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".ReadData"}, ReadData, e.rd);
                chk({e.name, ".AccessErr"}, {31'b0, AccessErr}, {31'b0, e.err});
                chk({e.name, ".ErrSticky"}, {31'b0, ErrSticky}, {31'b0, e.sticky});
                chk({e.name, ".ErrAddr"}, ErrAddr, e.eaddr);
            end
        end else if (!reset) begin
            chk("idle.AccessErr", {31'b0, AccessErr}, 32'h0);
            chk("idle.ReadData", ReadData, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        MemSize = 2'b11;
        MemUnsigned = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("reset.ErrSticky", {31'b0, ErrSticky}, 32'h0);
        chk("reset.ErrAddr", ErrAddr, 32'h0);
        chk("reset.ReadData", ReadData, 32'h0);

        // Reset clears RAM; a load during reset returns zero
        issue("sw_10",      0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0);
        issue("lw_10_rst",  1, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h0, 0, 0, 32'h0);
        issue("lw_10_post", 0, 1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h0, 0, 0, 32'h0);

        // Byte lanes and extension
        issue("sw_20",  0, 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 32'h0,        0, 0, 32'h0);
        issue("lb_20",  0, 1, 0, 2'b00, 0, 32'h20, 32'h0,        32'h00000001, 0, 0, 32'h0);
        issue("lb_21",  0, 1, 0, 2'b00, 0, 32'h21, 32'h0,        32'h0000007F, 0, 0, 32'h0);
        issue("lb_22",  0, 1, 0, 2'b00, 0, 32'h22, 32'h0,        32'hFFFFFFFF, 0, 0, 32'h0);
        issue("lbu_22", 0, 1, 0, 2'b00, 1, 32'h22, 32'h0,        32'h000000FF, 0, 0, 32'h0);
        issue("lb_23",  0, 1, 0, 2'b00, 0, 32'h23, 32'h0,        32'hFFFFFF80, 0, 0, 32'h0);
        issue("lh_22",  0, 1, 0, 2'b01, 0, 32'h22, 32'h0,        32'hFFFF80FF, 0, 0, 32'h0);
        issue("lhu_22", 0, 1, 0, 2'b01, 1, 32'h22, 32'h0,        32'h000080FF, 0, 0, 32'h0);
        issue("lw_20u", 0, 1, 0, 2'b10, 1, 32'h20, 32'h0,        32'h80FF7F01, 0, 0, 32'h0);
        idle(1'b0);

        // Partial stores preserve other lanes
        issue("sw_40", 0, 0, 1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0,        0, 0, 32'h0);
        issue("sb_41", 0, 0, 1, 2'b00, 0, 32'h41, 32'h000000AA, 32'h0,        0, 0, 32'h0);
        issue("sh_42", 0, 0, 1, 2'b01, 0, 32'h42, 32'h0000BEEF, 32'h0,        0, 0, 32'h0);
        issue("lw_40", 0, 1, 0, 2'b10, 0, 32'h40, 32'h0,        32'hBEEFAA44, 0, 0, 32'h0);

        // Misaligned store suppressed, first error captured
        issue("sw_50",     0, 0, 1, 2'b10, 0, 32'h50, 32'h12345678, 32'h0,        0, 0, 32'h0);
        issue("sw_52_bad", 0, 0, 1, 2'b10, 0, 32'h52, 32'hFFFFFFFF, 32'h0,        1, 0, 32'h0);
        issue("lh_51_bad", 0, 1, 0, 2'b01, 0, 32'h51, 32'h0,        32'h0,        1, 1, 32'h52);
        issue("lw_50",     0, 1, 0, 2'b10, 0, 32'h50, 32'h0,        32'h12345678, 0, 1, 32'h52);

        // Address wrap
        issue("sw_400", 0, 0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        0, 1, 32'h52);
        issue("lw_000", 0, 1, 0, 2'b10, 0, 32'h000, 32'h0,        32'hCAFEF00D, 0, 1, 32'h52);

        // Read returns old contents; new value visible one cycle after the store
        issue("sw_08_old", 0, 0, 1, 2'b10, 0, 32'h8, 32'h00000055, 32'h0,        0, 1, 32'h52);
        issue("lw_08_old", 0, 1, 0, 2'b10, 0, 32'h8, 32'h0,        32'h00000055, 0, 1, 32'h52);
        issue("sw_08_new", 0, 0, 1, 2'b10, 0, 32'h8, 32'h00000001, 32'h0,        0, 1, 32'h52);
        issue("lw_08_new", 0, 1, 0, 2'b10, 0, 32'h8, 32'h0,        32'h00000001, 0, 1, 32'h52);

        // Illegal combinations
        issue("rw_both",   0, 1, 1, 2'b10, 0, 32'h8, 32'h0000FFFF, 32'h0,        1, 1, 32'h52);
        issue("lw_08_chk", 0, 1, 0, 2'b10, 0, 32'h8, 32'h0,        32'h00000001, 0, 1, 32'h52);
        issue("lsz11",     0, 1, 0, 2'b11, 0, 32'h0, 32'h0,        32'h0,        1, 1, 32'h52);
        issue("ssz11",     0, 0, 1, 2'b11, 0, 32'h0, 32'h000000EE, 32'h0,        1, 1, 32'h52);
        issue("lw_000_b",  0, 1, 0, 2'b10, 0, 32'h0, 32'h0,        32'hCAFEF00D, 0, 1, 32'h52);
        idle(1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        chk("scoreboard_drained", sb.size(), 32'h0);
        idle(1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

MEM-stage data memory for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It takes the effective address (ALU result) and store data from EX/MEM and performs byte, halfword or word stores into an internal synchronous-write RAM. It returns load data combinationally in the same cycle so MEM/WB can capture it as Data2Write. It also detects misaligned or illegal accesses and records the first one for debug.

## Interface

Parameters:
- ADDR_WIDTH, default 8: word-address width; RAM depth = 2**ADDR_WIDTH 32-bit words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  load request this cycle.
- MemWrite  in  1  store request this cycle.
- MemSize  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- MemUnsigned  in  1  loads only: 1 zero-extend, 0 sign-extend.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data; the low byte/half/word is used.
- ReadData  out  32  load result, combinational.
- AccessErr  out  1  combinational error flag for the current access.
- ErrSticky  out  1  registered; set by the first error since reset.
- ErrAddr  out  32  registered; byte address of the first error.

## Operation

- **Addressing**
  - Word index = ALUResult[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
  - Lane = ALUResult[1:0]. Little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Halfword at lane 0 occupies [15:0]; at lane 2 it occupies [31:16].
- **Error condition**
  - AccessErr = (MemRead | MemWrite) & illegal, where illegal is any of:
    - MemSize=11;
    - MemSize=01 with ALUResult[0]=1;
    - MemSize=10 with ALUResult[1:0]≠00;
    - MemRead & MemWrite both high.
  - AccessErr is 0 when neither MemRead nor MemWrite is high.
- **Store**
  - On a rising edge with MemWrite=1, AccessErr=0 and reset=0, only the addressed lanes of the addressed word are written.
  - Byte: WriteData[7:0] into the lane. Half: WriteData[15:0] into its 2 lanes. Word: all 32 bits.
  - Non-addressed lanes are preserved.
  - An erroring store modifies nothing.
- **Load**
  - When MemRead=1 and AccessErr=0, the addressed byte or half is extracted and extended per MemUnsigned. A word is returned unchanged and MemUnsigned is ignored.
  - ReadData = 0 when MemRead=0, when AccessErr=1, or when reset=1.
- **Error capture**
  - On a rising edge with AccessErr=1 and ErrSticky=0: ErrSticky←1 and ErrAddr←ALUResult.
  - Later errors do not overwrite either register. Only reset clears them.
- **Reset**
  - At a rising edge with reset=1, every RAM word←0, ErrSticky←0 and ErrAddr←0.
  - Reset overrides any store or error capture in the same cycle.
  - Reset mid-sequence discards all prior stores.

## Timing

- Reset values: ReadData=0, AccessErr=0 (no request), ErrSticky=0, ErrAddr=0, RAM all zero.
- Load latency is 0 cycles: ReadData is valid in the same cycle as the request and is captured by MEM/WB at the next edge.
- Store latency is 1 edge: a store issued in cycle N is visible to a load in cycle N+1.
- A load in cycle N to the word being stored in cycle N returns the pre-store contents.
- AccessErr is combinational and is not registered here. ErrSticky/ErrAddr become visible in the cycle after the first erroring request.
- No stalls and no handshake: exactly one access per cycle, and the request is accepted whenever presented.

## Test plan

- **Reset clears RAM:**
  - Stimulus: word store 0xDEADBEEF at 0x10, then reset for 1 cycle, then lw 0x10.
  - Required: ReadData=0x00000000; ErrSticky=0; ErrAddr=0.
- **Byte lanes and extension:**
  - Stimulus: sw 0x80FF7F01 at 0x20; then lb, lbu and lb at 0x20–0x23; then lh/lhu at 0x22.
  - Required: lb 0x20→0x00000001; lb 0x21→0x0000007F; lb 0x22→0xFFFFFFFF; lbu 0x22→0x000000FF; lb 0x23→0xFFFFFF80; lh 0x22→0xFFFF80FF; lhu 0x22→0x000080FF.
- **Partial stores preserve other lanes:**
  - Stimulus: sw 0x11223344 at 0x40; sb 0xAA at 0x41; sh 0xBEEF at 0x42.
  - Required: lw 0x40→0xBEEFAA44.
- **Misaligned store suppressed and first error captured:**
  - Stimulus: sw 0x12345678 at 0x50; then sw 0xFFFFFFFF at 0x52; then lh at 0x51.
  - Required: AccessErr=1 on both bad accesses; lw 0x50 still returns 0x12345678; ErrAddr=0x00000052 (not 0x51); ErrSticky=1; ReadData=0 on the bad lh.
- **Address wrap, read-before-write, illegal combos:**
  - Stimulus (ADDR_WIDTH=8):
    - sw 0xCAFEF00D at 0x400, then lw 0x000;
    - in one cycle, sw 0x1 at 0x8 while a prior lw to 0x8 returns its old value;
    - MemRead=MemWrite=1, and MemSize=11.
  - Required:
    - lw 0x000 returns 0xCAFEF00D;
    - the same-cycle load returns the old value, and the new value appears the next cycle;
    - MemRead=MemWrite=1 gives AccessErr=1, no write, ReadData=0;
    - MemSize=11 gives AccessErr=1.
